// File: rtl/mgmt_frame_rx.sv
// Receive framer for the LTPI management link: comma hunt, CRC-8 check, alignment tracking.
// Latency: frame result (frm_vld/crc_err/overflow) registered one cycle after the CRC byte is sampled.
// Backpressure: one-entry valid/ready holding register; a good frame arriving while it is full is dropped with an overflow pulse.
// Optional: define MGMT_FRAME_RX_ERR_CNT_EN to build the frm_cnt/crc_err_cnt counters (tied to 0 otherwise).
module mgmt_frame_rx #(
    parameter int          FRAME_BYTES = 16,
    parameter int          LOCK_CNT    = 7,
    parameter int          UNLOCK_CNT  = 3,
    parameter logic [7:0]  COMMA       = 8'hBC
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [7:0]                     rx_data,
    input  logic                           rx_k,
    input  logic                           rx_vld,
    output logic [8*(FRAME_BYTES-2)-1:0]   frm_data,
    output logic                           frm_vld,
    input  logic                           frm_rdy,
    output logic                           aligned,
    output logic                           crc_err,
    output logic                           overflow,
    output logic [15:0]                    frm_cnt,
    output logic [15:0]                    crc_err_cnt
);

    localparam int         PAY_BYTES = FRAME_BYTES - 2;
    localparam int         PAY_W     = 8 * PAY_BYTES;
    localparam logic [5:0] LAST_IDX  = 6'(FRAME_BYTES - 1);
    localparam logic [7:0] LOCK_C    = 8'(LOCK_CNT);
    localparam logic [7:0] UNLOCK_C  = 8'(UNLOCK_CNT);

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         idx_q, idx_d;
    logic [7:0]         crc_q, crc_d;
    logic [PAY_W-1:0]   shadow_q, shadow_d;
    logic [7:0]         good_cnt_q, good_cnt_d;
    logic [7:0]         bad_cnt_q, bad_cnt_d;
    logic               aligned_q, aligned_d;
    logic               frm_vld_q, frm_vld_d;
    logic [PAY_W-1:0]   frm_data_q, frm_data_d;
    logic               crc_err_q, crc_err_d;
    logic               overflow_q, overflow_d;

    logic               frame_good;
    logic               frame_bad;
    logic               deliver;
    logic               hold_free;

    // CRC-8, polynomial 0x07, MSB first, one byte per call
    function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int b = 0; b < 8; b++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction

    // Framing FSM: comma hunt, payload capture into the shadow, CRC compare on the last byte
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        crc_d      = crc_q;
        shadow_d   = shadow_q;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        if (rx_vld) begin
            case (state_q)
                HUNT: begin
                    if (rx_k && (rx_data == COMMA)) begin
                        state_d = RECV;
                        idx_d   = 6'd1;
                        crc_d   = 8'h00;
                    end
                end
                RECV: begin
                    if (rx_k) begin
                        // Any K-char inside a frame kills it; a comma doubles as the next SOF
                        frame_bad = 1'b1;
                        if (rx_data == COMMA) begin
                            idx_d = 6'd1;
                            crc_d = 8'h00;
                        end else begin
                            state_d = HUNT;
                        end
                    end else if (idx_q == LAST_IDX) begin
                        if (rx_data == crc_q) begin
                            frame_good = 1'b1;
                        end else begin
                            frame_bad = 1'b1;
                        end
                        state_d = HUNT;
                    end else begin
                        for (int s = 0; s < PAY_BYTES; s++) begin
                            if (idx_q == 6'(s + 1)) begin
                                shadow_d[s*8 +: 8] = rx_data;
                            end
                        end
                        crc_d = crc8_upd(crc_q, rx_data);
                        idx_d = idx_q + 6'd1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Alignment tracking, saturating good/bad run counters
    always_comb begin
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        aligned_d  = aligned_q;
        if (frame_good) begin
            bad_cnt_d = 8'd0;
            if (good_cnt_q < LOCK_C) begin
                good_cnt_d = good_cnt_q + 8'd1;
            end
            if (good_cnt_d >= LOCK_C) begin
                aligned_d = 1'b1;
            end
        end
        if (frame_bad) begin
            good_cnt_d = 8'd0;
            if (bad_cnt_q < UNLOCK_C) begin
                bad_cnt_d = bad_cnt_q + 8'd1;
            end
            if (bad_cnt_d >= UNLOCK_C) begin
                aligned_d = 1'b0;
            end
        end
    end

    // Holding register: deliver only when aligned after this frame's update; accept and reload may coincide
    always_comb begin
        deliver    = frame_good && aligned_d;
        hold_free  = !frm_vld_q || frm_rdy;
        frm_vld_d  = frm_vld_q;
        frm_data_d = frm_data_q;
        overflow_d = 1'b0;
        crc_err_d  = frame_bad;
        if (deliver && hold_free) begin
            frm_vld_d  = 1'b1;
            frm_data_d = shadow_q;
        end else if (deliver) begin
            overflow_d = 1'b1;
        end else if (frm_vld_q && frm_rdy) begin
            frm_vld_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HUNT;
            idx_q      <= 6'd0;
            crc_q      <= 8'h00;
            shadow_q   <= '0;
            good_cnt_q <= 8'd0;
            bad_cnt_q  <= 8'd0;
            aligned_q  <= 1'b0;
            frm_vld_q  <= 1'b0;
            frm_data_q <= '0;
            crc_err_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            crc_q      <= crc_d;
            shadow_q   <= shadow_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            aligned_q  <= aligned_d;
            frm_vld_q  <= frm_vld_d;
            frm_data_q <= frm_data_d;
            crc_err_q  <= crc_err_d;
            overflow_q <= overflow_d;
        end
    end

    assign frm_data = frm_data_q;
    assign frm_vld  = frm_vld_q;
    assign aligned  = aligned_q;
    assign crc_err  = crc_err_q;
    assign overflow = overflow_q;

`ifdef MGMT_FRAME_RX_ERR_CNT_EN
    logic [15:0] frm_cnt_q, frm_cnt_d;
    logic [15:0] crc_err_cnt_q, crc_err_cnt_d;

    // Saturating statistics; every good frame counts, delivered or not
    always_comb begin
        frm_cnt_d     = frm_cnt_q;
        crc_err_cnt_d = crc_err_cnt_q;
        if (frame_good && (frm_cnt_q != 16'hFFFF)) begin
            frm_cnt_d = frm_cnt_q + 16'd1;
        end
        if (frame_bad && (crc_err_cnt_q != 16'hFFFF)) begin
            crc_err_cnt_d = crc_err_cnt_q + 16'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (reset) begin
            frm_cnt_q     <= 16'd0;
            crc_err_cnt_q <= 16'd0;
        end else begin
            frm_cnt_q     <= frm_cnt_d;
            crc_err_cnt_q <= crc_err_cnt_d;
        end
    end

    assign frm_cnt     = frm_cnt_q;
    assign crc_err_cnt = crc_err_cnt_q;
`else
    assign frm_cnt     = 16'd0;
    assign crc_err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_mgmt_frame_rx.sv
// Directed bench for mgmt_frame_rx with default parameters (16-byte frames, 14-byte payload).
// Inputs change on the falling edge; outputs are checked on the falling edge after the sampling rising edge.
// Payloads are zero except byte 14, so the CRC is the single-byte table entry for that value.
module tb_mgmt_frame_rx;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   rx_data;
    logic         rx_k;
    logic         rx_vld;
    logic [111:0] frm_data;
    logic         frm_vld;
    logic         frm_rdy;
    logic         aligned;
    logic         crc_err;
    logic         overflow;
    logic [15:0]  frm_cnt;
    logic [15:0]  crc_err_cnt;

    int nvec = 0;
    int nerr = 0;
    int exp_frm = 0;
    int exp_bad = 0;

    localparam logic [7:0]   COMMA = 8'hBC;
    localparam logic [111:0] PZERO = 112'd0;
    // byte 14 = 0x01 -> CRC 0x07; 0x02 -> 0x0E; 0x80 -> 0x89
    localparam logic [111:0] PAY_A = {8'h01, 104'd0};
    localparam logic [111:0] PAY_C = {8'h02, 104'd0};
    localparam logic [111:0] PAY_B = {8'h80, 104'd0};

    mgmt_frame_rx dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_k        (rx_k),
        .rx_vld      (rx_vld),
        .frm_data    (frm_data),
        .frm_vld     (frm_vld),
        .frm_rdy     (frm_rdy),
        .aligned     (aligned),
        .crc_err     (crc_err),
        .overflow    (overflow),
        .frm_cnt     (frm_cnt),
        .crc_err_cnt (crc_err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ecnt(input int v);
`ifdef MGMT_FRAME_RX_ERR_CNT_EN
        return 16'(v);
`else
        return 16'd0 + 16'(v * 0);
`endif
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] d, input logic k);
        @(negedge clk);
        rx_data = d;
        rx_k    = k;
        rx_vld  = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        rx_data = 8'h00;
        rx_k    = 1'b0;
        rx_vld  = 1'b0;
    endtask

    task automatic send_body(input logic [111:0] p);
        put(COMMA, 1'b1);
        for (int i = 0; i < 14; i++) put(p[i*8 +: 8], 1'b0);
    endtask

    task automatic send_frame(input logic [111:0] p, input logic [7:0] c);
        send_body(p);
        put(c, 1'b0);
    endtask

    initial begin
        reset   = 1'b1;
        rx_data = 8'h00;
        rx_k    = 1'b0;
        rx_vld  = 1'b0;
        frm_rdy = 1'b0;
        idle();
        idle();
        reset = 1'b0;
        idle();
        chk("rst_vld", frm_vld, 0);
        chk("rst_aligned", aligned, 0);
        chk("rst_data", frm_data, 0);
        chk("rst_crc_err", crc_err, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frm_cnt", frm_cnt, 0);
        chk("rst_err_cnt", crc_err_cnt, 0);

        // Lock on 7 zero frames; only the 7th is delivered
        frm_rdy = 1'b1;
        for (int f = 1; f <= 7; f++) begin
            send_frame(PZERO, 8'h00);
            idle();
            exp_frm++;
            chk("lock_aligned", aligned, (f == 7) ? 1 : 0);
            chk("lock_vld", frm_vld, (f == 7) ? 1 : 0);
            chk("lock_crc_err", crc_err, 0);
        end
        chk("lock_data", frm_data, 0);
        chk("lock_frm_cnt", frm_cnt, ecnt(exp_frm));
        idle();
        chk("lock_accept_clears", frm_vld, 0);

        // One bad CRC while locked
        send_frame(PZERO, 8'hFF);
        idle();
        exp_bad++;
        chk("bad1_crc_err", crc_err, 1);
        chk("bad1_vld", frm_vld, 0);
        chk("bad1_aligned", aligned, 1);
        chk("bad1_err_cnt", crc_err_cnt, ecnt(exp_bad));
        idle();
        chk("bad1_pulse_end", crc_err, 0);

        // Good frame clears the bad run, then three bad frames unlock
        send_frame(PZERO, 8'h00);
        idle();
        exp_frm++;
        chk("relock_deliver", frm_vld, 1);
        for (int f = 1; f <= 3; f++) begin
            send_frame(PZERO, 8'hFF);
            idle();
            exp_bad++;
            chk("unlock_crc_err", crc_err, 1);
            chk("unlock_aligned", aligned, (f == 3) ? 0 : 1);
        end
        chk("unlock_err_cnt", crc_err_cnt, ecnt(exp_bad));

        // Relock
        for (int f = 1; f <= 7; f++) begin
            send_frame(PZERO, 8'h00);
            idle();
            exp_frm++;
            chk("relock2_vld", frm_vld, (f == 7) ? 1 : 0);
        end
        chk("relock2_aligned", aligned, 1);
        idle();

        // Backpressure: hold A, drop C with overflow, then load B on the accept cycle
        frm_rdy = 1'b0;
        send_frame(PAY_A, 8'h07);
        idle();
        exp_frm++;
        chk("hold_vld", frm_vld, 1);
        chk("hold_data", frm_data, PAY_A);
        idle();
        idle();
        chk("hold_stable", frm_data, PAY_A);
        send_frame(PAY_C, 8'h0E);
        idle();
        exp_frm++;
        chk("ovf_pulse", overflow, 1);
        chk("ovf_data_kept", frm_data, PAY_A);
        chk("ovf_vld_kept", frm_vld, 1);
        chk("ovf_frm_cnt", frm_cnt, ecnt(exp_frm));
        idle();
        chk("ovf_pulse_end", overflow, 0);
        send_body(PAY_B);
        put(8'h89, 1'b0);
        frm_rdy = 1'b1;
        idle();
        exp_frm++;
        chk("reload_vld", frm_vld, 1);
        chk("reload_data", frm_data, PAY_B);
        chk("reload_no_ovf", overflow, 0);
        idle();
        chk("reload_accepted", frm_vld, 0);

        // Comma at idx 5 aborts the frame and starts a new one
        put(COMMA, 1'b1);
        for (int i = 0; i < 4; i++) put(8'h5A, 1'b0);
        put(COMMA, 1'b1);
        put(8'h00, 1'b0);
        exp_bad++;
        chk("comma_abort_err", crc_err, 1);
        for (int i = 0; i < 13; i++) put(8'h00, 1'b0);
        put(8'h00, 1'b0);
        idle();
        exp_frm++;
        chk("comma_next_good", frm_vld, 1);
        chk("comma_no_extra_err", crc_err, 0);
        chk("comma_err_cnt", crc_err_cnt, ecnt(exp_bad));

        // Non-comma K-char mid-frame returns to HUNT; following data is ignored
        put(COMMA, 1'b1);
        for (int i = 0; i < 3; i++) put(8'h33, 1'b0);
        put(8'h1C, 1'b1);
        put(8'h55, 1'b0);
        exp_bad++;
        chk("kchar_err", crc_err, 1);
        put(8'h55, 1'b0);
        put(8'h55, 1'b0);
        put(COMMA, 1'b1);
        put(8'h00, 1'b0);
        chk("kchar_hunt_sof", crc_err, 0);
        for (int i = 0; i < 13; i++) put(8'h00, 1'b0);
        put(8'h00, 1'b0);
        idle();
        exp_frm++;
        chk("kchar_next_good", frm_vld, 1);
        chk("kchar_aligned", aligned, 1);
        chk("kchar_frm_cnt", frm_cnt, ecnt(exp_frm));
        chk("kchar_err_cnt", crc_err_cnt, ecnt(exp_bad));

        // Reset mid-frame while aligned with a held payload
        frm_rdy = 1'b0;
        send_frame(PAY_A, 8'h07);
        idle();
        chk("prerst_vld", frm_vld, 1);
        put(COMMA, 1'b1);
        for (int i = 0; i < 5; i++) put(8'h11, 1'b0);
        @(negedge clk);
        rx_vld = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_frm = 0;
        exp_bad = 0;
        chk("midrst_vld", frm_vld, 0);
        chk("midrst_aligned", aligned, 0);
        chk("midrst_data", frm_data, 0);
        chk("midrst_frm_cnt", frm_cnt, 0);
        chk("midrst_err_cnt", crc_err_cnt, 0);
        frm_rdy = 1'b1;
        for (int i = 0; i < 9; i++) put(8'h00, 1'b0);
        for (int f = 1; f <= 7; f++) begin
            send_frame(PAY_B, 8'h89);
            idle();
            exp_frm++;
            chk("postrst_vld", frm_vld, (f == 7) ? 1 : 0);
            chk("postrst_aligned", aligned, (f == 7) ? 1 : 0);
        end
        chk("postrst_data", frm_data, PAY_B);
        chk("postrst_frm_cnt", frm_cnt, ecnt(exp_frm));
        chk("postrst_err_cnt", crc_err_cnt, ecnt(exp_bad));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mgmt_frame_rx.md
Name: mgmt_frame_rx

Overview:
- Receive-side framer for the LTPI management link. It is the counterpart of the management PHY transmit path.
- Consumes 8b/10b-decoded bytes, finds comma-delimited frames, checks CRC-8 and tracks link alignment.
- Presents each good payload on a valid/ready holding register to the management logic.
- Sits between the PHY deserializer/decoder and the management register/tunnel logic.

Parameters:
- FRAME_BYTES, 16, total frame length in bytes including comma and CRC; legal range 4..32.
- LOCK_CNT, 7, consecutive good frames needed to assert aligned.
- UNLOCK_CNT, 3, consecutive bad frames needed to drop aligned.
- COMMA, 8'hBC, K-character value that marks start of frame (K28.5).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  decoded byte.
- rx_k  in  1  rx_data is a K-character.
- rx_vld  in  1  byte strobe; rx_data/rx_k are sampled only when high.
- frm_data  out  8*(FRAME_BYTES-2)  payload; byte 1 is at [7:0].
- frm_vld  out  1  payload available.
- frm_rdy  in  1  consumer accepts the payload when frm_vld && frm_rdy.
- aligned  out  1  link locked.
- crc_err  out  1  one-cycle pulse per bad frame.
- overflow  out  1  one-cycle pulse when a good frame is dropped because the holding register is full.
- frm_cnt  out  16  good-frame count.
- crc_err_cnt  out  16  bad-frame count.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset values: all outputs 0, frm_data 0, FSM in HUNT, all internal counters 0.
- FSM HUNT:
  - On rx_vld && rx_k && rx_data==COMMA: go to RECV, set idx=1, crc=8'h00.
  - Any other byte is ignored.
- FSM RECV, on each rx_vld:
  - idx 1..FRAME_BYTES-2: store the byte into payload shadow slot idx-1; update crc. Then idx++.
  - idx FRAME_BYTES-1: compare the byte with crc. Equal means good frame, else bad frame. Return to HUNT.
  - rx_k=1 with COMMA at any idx: the current frame is bad; restart RECV with idx=1, crc=0. The comma is consumed as the new SOF.
  - rx_k=1 with a non-COMMA value: the frame is bad; go to HUNT.
  - Cycles without rx_vld are ignored. There is no timeout.
- CRC-8:
  - Polynomial x^8+x^2+x+1 (0x07), init 0x00, MSB-first, no reflection, no final XOR.
  - Covers payload bytes only (comma and CRC byte excluded).
- Frame completion result is registered: frm_vld, crc_err and overflow update in the cycle after the terminating byte is sampled.
- Alignment:
  - Good frame: good_cnt++ (saturating at LOCK_CNT), bad_cnt=0. When good_cnt reaches LOCK_CNT, aligned<=1.
  - Bad frame: bad_cnt++ (saturating), good_cnt=0. When bad_cnt reaches UNLOCK_CNT, aligned<=0. Once aligned is 0, bad frames keep it 0.
- Delivery:
  - A good frame is delivered only if aligned is 1 after that frame's alignment update. The LOCK_CNT-th good frame is therefore delivered.
  - Delivery means the holding register loads frm_data and frm_vld<=1.
  - The holding register is free if frm_vld==0, or if frm_rdy==1 in the same cycle (simultaneous accept and load is allowed, no bubble).
  - If the register is not free: the frame is dropped, overflow pulses, and frm_cnt still increments.
- Handshake: frm_vld stays high and frm_data stays stable until accepted. Accept with no new load clears frm_vld.
- Counters: frm_cnt and crc_err_cnt are 16-bit and saturate at 16'hFFFF. Undelivered good frames (before lock) also count.
- Reset mid-frame discards the partial frame and clears aligned.

Optional Feature:
- Macro: MGMT_FRAME_RX_ERR_CNT_EN.
- Defined: frm_cnt and crc_err_cnt behave as above.
- Undefined: the counter registers are not built; frm_cnt and crc_err_cnt are tied to 0.
- crc_err and overflow pulses are unaffected. Ports exist in both builds.

Test Plan:
- Reset, then 7 frames of COMMA + 14×8'h00 + CRC 8'h00 with frm_rdy=1:
  - aligned rises 1 cycle after frame 7's CRC byte; only frame 7 gives frm_vld with frm_data=0; frm_cnt=7.
- Locked, one frame whose CRC byte is 8'hFF:
  - crc_err 1-cycle pulse, crc_err_cnt=1, no frm_vld, aligned stays 1.
  - Then 3 bad frames in a row: aligned=0 after the 3rd.
- Locked, frm_rdy=0, two good frames:
  - First frame held stable; second frame gives overflow pulse, frm_cnt +2.
  - Raise frm_rdy in the same cycle a third frame completes: third frame loads with no gap.
- COMMA injected at idx 5 of a frame, followed by a full good frame:
  - First frame counted bad (crc_err pulse); second frame good, no extra error.
- Non-comma K-char (rx_k=1, 8'h1C) mid-frame:
  - Bad frame, FSM returns to HUNT; data bytes before the next COMMA are ignored.
- reset asserted mid-frame while aligned=1:
  - All outputs 0 the next cycle; a subsequent good frame is not delivered until 7 consecutive good frames.
